// File: rtl/bus_arb_pkg.sv
// Shared definitions for the CPU/DMA bus arbiter: FSM state encoding and bus widths.
package bus_arb_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int BLOCK_SIZE = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_COOL    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/bus_arb_mux.sv
// Memory-port multiplexer: DMA drives the memory in GRANT, the bus is quiet in RELEASE,
// and the CPU passes straight through in every other state.
module bus_arb_mux
    import bus_arb_pkg::*;
(
    input  arb_state_t              state,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    input  logic [WORD_SIZE-1:0]    cpu_addr,
    input  logic [BLOCK_SIZE-1:0]   cpu_wdata,
    input  logic                    dma_write,
    input  logic [WORD_SIZE-1:0]    dma_addr,
    input  logic [BLOCK_SIZE-1:0]   dma_wdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [WORD_SIZE-1:0]    mem_addr,
    output logic [BLOCK_SIZE-1:0]   mem_wdata
);

    always_comb begin
        mem_read  = cpu_read;
        mem_write = cpu_write;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        case (state)
            ST_GRANT: begin
                // DMA write strobes only ever reach memory from here
                mem_read  = 1'b0;
                mem_write = dma_write;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            ST_RELEASE: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// CPU/DMA bus arbiter with post-release CPU cooldown and grant counting.
// Define BUS_ARB_TIMEOUT_EN to add DMA tenure tracking and the sticky timeout_err flag.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    input  logic                    cpu_busy,
    input  logic [WORD_SIZE-1:0]    cpu_addr,
    input  logic [BLOCK_SIZE-1:0]   cpu_wdata,
    input  logic                    dma_br,
    input  logic                    dma_write,
    input  logic [WORD_SIZE-1:0]    dma_addr,
    input  logic [BLOCK_SIZE-1:0]   dma_wdata,
    output logic                    dma_bg,
    output logic                    cpu_stall,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [WORD_SIZE-1:0]    mem_addr,
    output logic [BLOCK_SIZE-1:0]   mem_wdata,
    output logic [7:0]              grant_cnt,
    output logic                    timeout_err
);

    // COOL exits when the counter reaches zero, so it is loaded one short of the length
    localparam logic [3:0] COOL_LOAD = (COOLDOWN_CYCLES > 0) ? 4'(COOLDOWN_CYCLES - 1) : 4'd0;

    arb_state_t state_reg;
    arb_state_t state_next;
    logic [3:0] cool_cnt_reg;
    logic [7:0] grant_cnt_reg;
    logic       dma_bg_reg;
    logic       grant_entry;

    assign grant_entry = (state_next == ST_GRANT) && (state_reg != ST_GRANT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (dma_br) begin
                    state_next = cpu_busy ? ST_WAIT : ST_GRANT;
                end
            end
            ST_WAIT: begin
                if (!dma_br) begin
                    state_next = ST_IDLE;
                end else if (!cpu_busy) begin
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!dma_br) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = (COOLDOWN_CYCLES > 0) ? ST_COOL : ST_IDLE;
            end
            ST_COOL: begin
                if (cool_cnt_reg == 4'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall = (cpu_read | cpu_write) &&
                    ((state_reg == ST_GRANT) || (state_reg == ST_RELEASE) ||
                     ((state_reg == ST_WAIT) && !cpu_busy));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cool_cnt_reg  <= 4'd0;
            grant_cnt_reg <= 8'd0;
            dma_bg_reg    <= 1'b0;
        end else begin
            dma_bg_reg <= (state_next == ST_GRANT);
            if (grant_entry) begin
                grant_cnt_reg <= grant_cnt_reg + 8'd1;
            end
            if (state_reg == ST_RELEASE) begin
                cool_cnt_reg <= COOL_LOAD;
            end else if ((state_reg == ST_COOL) && (cool_cnt_reg != 4'd0)) begin
                cool_cnt_reg <= cool_cnt_reg - 4'd1;
            end
        end
    end

    assign dma_bg    = dma_bg_reg;
    assign grant_cnt = grant_cnt_reg;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] tenure_reg;
    logic       timeout_err_reg;

    // tenure_reg holds completed GRANT cycles; the flag sets as the limit-th one ends
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tenure_reg      <= 8'd0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (grant_entry) begin
                tenure_reg <= 8'd0;
            end else if ((state_reg == ST_GRANT) && (tenure_reg != 8'hFF)) begin
                tenure_reg <= tenure_reg + 8'd1;
            end
            if ((state_reg == ST_GRANT) && ((int'(tenure_reg) + 1) >= TIMEOUT_CYCLES)) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    // No tenure tracking in this build; the flag can never rise for a legal limit
    assign timeout_err = 1'b0 & (TIMEOUT_CYCLES < 1);
`endif

    bus_arb_mux u_mux (
        .state     (state_reg),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dma_write (dma_write),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, reset/timeout sequences,
// and randomized traffic against a cycle-level ownership model.
module tb_bus_arbiter;

    localparam int COOL = 4;
    localparam int TMO  = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        cpu_read, cpu_write, cpu_busy;
    logic [15:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        dma_br, dma_write;
    logic [15:0] dma_addr;
    logic [63:0] dma_wdata;
    logic        dma_bg, cpu_stall, mem_read, mem_write;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  grant_cnt;
    logic        timeout_err;

    bus_arbiter #(.COOLDOWN_CYCLES(COOL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_busy(cpu_busy),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_br(dma_br), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_bg(dma_bg), .cpu_stall(cpu_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .grant_cnt(grant_cnt),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Ownership model: who holds the bus, plus how many post-release quiet cycles remain
    bit m_valid = 1'b0;
    bit m_grant, m_wait, m_terr;
    int m_quiet, m_grants, m_tenure;

    task automatic model_compare();
        bit rel;
        logic [15:0] ea;
        logic [63:0] ew;
        logic er, ew_s;
        rel = !m_grant && (m_quiet == COOL + 1);
        if (m_grant) begin
            er = 0; ew_s = dma_write; ea = dma_addr; ew = dma_wdata;
        end else if (rel) begin
            er = 0; ew_s = 0; ea = '0; ew = '0;
        end else begin
            er = cpu_read; ew_s = cpu_write; ea = cpu_addr; ew = cpu_wdata;
        end
        chk("m_dma_bg", dma_bg, m_grant);
        chk("m_cpu_stall", cpu_stall,
            (cpu_read | cpu_write) && (m_grant || rel || (m_wait && !cpu_busy)));
        chk("m_mem_read", mem_read, er);
        chk("m_mem_write", mem_write, ew_s);
        chk("m_mem_addr", mem_addr, ea);
        chk("m_mem_wdata", mem_wdata, ew);
        chk("m_grant_cnt", grant_cnt, m_grants % 256);
        chk("m_timeout_err", timeout_err, m_terr);
    endtask

    task automatic model_update(bit rst_n_i, bit br, bit busy);
        if (!rst_n_i) begin
            m_grant = 0; m_wait = 0; m_terr = 0; m_quiet = 0; m_grants = 0; m_tenure = 0;
            m_valid = 1;
        end else if (m_grant) begin
            m_tenure++;
            if (TO_EN && m_tenure >= TMO) m_terr = 1;
            if (!br) begin
                m_grant = 0;
                m_quiet = COOL + 1;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (br && !busy) begin
            m_grant = 1; m_wait = 0; m_grants++; m_tenure = 0;
        end else begin
            m_wait = br;
        end
    endtask

    task automatic apply(bit rst_n_i, bit br, bit busy, bit rd, bit wr, bit dwr);
        reset_n   = rst_n_i;
        dma_br    = br;
        cpu_busy  = busy;
        cpu_read  = rd;
        cpu_write = wr;
        dma_write = dwr;
        cpu_addr  = 16'($urandom);
        dma_addr  = 16'($urandom);
        cpu_wdata = {$urandom, $urandom};
        dma_wdata = {$urandom, $urandom};
        @(negedge clk);
        if (m_valid) model_compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update(reset_n, dma_br, cpu_busy);
        #1;
    endtask

    task automatic step(bit rst_n_i, bit br, bit busy, bit rd, bit wr, bit dwr);
        apply(rst_n_i, br, busy, rd, wr, dwr);
        advance();
    endtask

    typedef struct {
        bit br, busy, rd, wr, dwr;
        bit bg, stall, mrd, mwr;
        int sel;   // 0 = CPU passes through, 1 = DMA drives, 2 = bus zeroed
        int gcnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(bit br, bit busy, bit rd, bit wr, bit dwr,
                       bit bg, bit stall, bit mrd, bit mwr, int sel, int gcnt);
        vec_t v;
        v.br = br; v.busy = busy; v.rd = rd; v.wr = wr; v.dwr = dwr;
        v.bg = bg; v.stall = stall; v.mrd = mrd; v.mwr = mwr; v.sel = sel; v.gcnt = gcnt;
        tbl.push_back(v);
    endtask

    initial begin
        bit br_r;
        // Vectors start right after reset; each row's outputs reflect the state left by earlier rows
        add(0,0,0,0,0, 0,0,0,0,0,0);   // reset state
        add(1,0,0,0,0, 0,0,0,0,0,0);   // request from IDLE
        add(1,0,1,0,1, 1,1,0,1,1,1);   // granted one cycle later, DMA write reaches memory
        add(1,0,1,0,0, 1,1,0,0,1,1);
        add(0,0,1,0,0, 1,1,0,0,1,1);   // request dropped
        add(1,0,1,0,1, 0,1,0,0,2,1);   // RELEASE: bus quiet, DMA write blocked
        add(1,0,1,0,0, 0,0,1,0,0,1);   // first COOL cycle: stall clears
        for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0,0,0,0,1);
        add(1,0,0,0,0, 0,0,0,0,0,1);   // IDLE again, request seen
        add(1,0,0,0,0, 1,0,0,0,1,2);
        add(0,0,0,0,0, 1,0,0,0,1,2);
        add(0,0,0,0,0, 0,0,0,0,2,2);
        for (int i = 0; i < 4; i++) add(0,0,0,1,0, 0,0,0,1,0,2);
        for (int i = 0; i < 3; i++) add(1,1,0,1,0, 0,0,0,1,0,2);   // busy holds off grant
        add(1,0,0,1,0, 0,1,0,1,0,2);   // WAIT with busy low: new access stalls
        add(1,0,0,0,0, 1,0,0,0,1,3);
        add(0,0,0,0,0, 1,0,0,0,1,3);
        add(0,0,0,0,0, 0,0,0,0,2,3);
        for (int i = 0; i < 4; i++) add(0,0,0,0,0, 0,0,0,0,0,3);
        add(1,1,0,0,0, 0,0,0,0,0,3);
        add(0,1,1,0,0, 0,0,1,0,0,3);   // withdrawn request in WAIT
        add(0,0,1,0,0, 0,0,1,0,0,3);
        add(1,0,0,0,0, 0,0,0,0,0,3);
        add(1,0,0,0,0, 1,0,0,0,1,4);

        step(0,0,0,0,0,0);
        step(0,0,0,0,0,0);

        foreach (tbl[i]) begin
            apply(1, tbl[i].br, tbl[i].busy, tbl[i].rd, tbl[i].wr, tbl[i].dwr);
            chk($sformatf("vec%0d_dma_bg", i), dma_bg, tbl[i].bg);
            chk($sformatf("vec%0d_cpu_stall", i), cpu_stall, tbl[i].stall);
            chk($sformatf("vec%0d_mem_read", i), mem_read, tbl[i].mrd);
            chk($sformatf("vec%0d_mem_write", i), mem_write, tbl[i].mwr);
            chk($sformatf("vec%0d_grant_cnt", i), grant_cnt, tbl[i].gcnt);
            case (tbl[i].sel)
                0: begin
                    chk($sformatf("vec%0d_addr", i), mem_addr, cpu_addr);
                    chk($sformatf("vec%0d_wdata", i), mem_wdata, cpu_wdata);
                end
                1: begin
                    chk($sformatf("vec%0d_addr", i), mem_addr, dma_addr);
                    chk($sformatf("vec%0d_wdata", i), mem_wdata, dma_wdata);
                end
                default: begin
                    chk($sformatf("vec%0d_addr", i), mem_addr, 16'h0);
                    chk($sformatf("vec%0d_wdata", i), mem_wdata, 64'h0);
                end
            endcase
            $display("vec %0d: br=%0b busy=%0b rd=%0b wr=%0b -> bg=%0b stall=%0b gcnt=%0d",
                     i, tbl[i].br, tbl[i].busy, tbl[i].rd, tbl[i].wr, dma_bg, cpu_stall, grant_cnt);
            advance();
        end

        // Reset in the middle of the fifth grant
        step(0,0,0,0,0,0);
        for (int g = 1; g <= 5; g++) begin
            step(1,1,0,0,0,0);
            if (g < 5) begin
                step(1,1,0,0,0,0);
                step(1,0,0,0,0,0);
                for (int c = 0; c < COOL + 1; c++) step(1,0,0,0,0,0);
            end
        end
        apply(1,1,0,1,0,0);
        chk("midgrant_bg", dma_bg, 1'b1);
        chk("midgrant_cnt", grant_cnt, 8'd5);
        advance();
        apply(0,1,0,1,0,0);
        advance();
        apply(1,0,0,1,0,0);
        chk("rst_bg", dma_bg, 1'b0);
        chk("rst_cnt", grant_cnt, 8'd0);
        chk("rst_no_release", mem_read, 1'b1);
        chk("rst_no_stall", cpu_stall, 1'b0);
        $display("reset mid-grant: bg=%0b gcnt=%0d mem_read=%0b", dma_bg, grant_cnt, mem_read);
        advance();

        // Long tenure: flag after the eighth GRANT cycle, grant kept, flag sticky through release
        step(1,1,0,0,0,0);
        for (int k = 0; k < TMO - 1; k++) step(1,1,0,0,0,0);
        apply(1,1,0,0,0,0);
        chk("tmo_before", timeout_err, 1'b0);
        advance();
        apply(1,1,0,0,0,0);
        chk("tmo_set", timeout_err, TO_EN);
        chk("tmo_bg_kept", dma_bg, 1'b1);
        advance();
        for (int k = 0; k < 11; k++) step(1,1,0,0,0,0);
        step(1,0,0,0,0,0);
        for (int k = 0; k < COOL + 2; k++) step(1,0,0,0,0,0);
        apply(1,0,0,0,0,0);
        chk("tmo_sticky", timeout_err, TO_EN);
        chk("tmo_released_bg", dma_bg, 1'b0);
        $display("timeout: err=%0b bg=%0b after release", timeout_err, dma_bg);
        advance();

        // Randomized traffic with a persistent DMA request and rare resets
        br_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) br_r = ~br_r;
            step(($urandom_range(0, 299) != 0), br_r, ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end
        $display("random phase done: gcnt=%0d", grant_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
